// File: rtl/hazard_unit.sv
// -----------------------------------------------------------------------------
// hazard_unit
//   Pipeline control for the 5-stage MIPS core. It covers the hazards that
//   operand forwarding cannot resolve: load-use, branch operands still in
//   flight in EX, and data-memory wait states. It drives the latch
//   enable/flush controls and the PC enable, and tracks the memory-wait
//   state, a deferred IF/ID flush and a sticky halt.
//
// Ports
//   CLK, RST                      core clock, asynchronous active-high reset
//   ihit, dhit                    fetch / data access completes this cycle
//   mem_dREN, mem_dWEN            MEM-stage instruction reads / writes dmem
//   mem_rfWEN, mem_dest           MEM-stage register write and destination
//   ex_dREN, ex_rfWEN, ex_dest    EX-stage load flag, register write, destination
//   dec_rs, dec_rt, dec_uses_rt   decode-stage source registers
//   dec_branch, dec_redirect      decode BEQ/BNE, taken branch/jump resolved
//   wb_halt                       HALT reached WB
//   pc_en                         PC update enable
//   ifid_en..memwb_en             pipeline latch enables
//   ifid_flush, idex_flush        synchronous bubble insert
//   halted                        sticky halt indication
//
// Optional feature (macro HAZARD_PERF_CNT_EN)
//   Adds the saturating counters stall_cycles, dwait_cycles and flush_count.
// -----------------------------------------------------------------------------
module hazard_unit #(
  parameter int REG_W = 5,
  parameter int CNT_W = 32
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             ihit,
  input  logic             dhit,
  input  logic             mem_dREN,
  input  logic             mem_dWEN,
  input  logic             mem_rfWEN,
  input  logic [REG_W-1:0] mem_dest,
  input  logic             ex_dREN,
  input  logic             ex_rfWEN,
  input  logic [REG_W-1:0] ex_dest,
  input  logic [REG_W-1:0] dec_rs,
  input  logic [REG_W-1:0] dec_rt,
  input  logic             dec_uses_rt,
  input  logic             dec_branch,
  input  logic             dec_redirect,
  input  logic             wb_halt,
  output logic             pc_en,
  output logic             ifid_en,
  output logic             idex_en,
  output logic             exmem_en,
  output logic             memwb_en,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic             halted
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] dwait_cycles,
  output logic [CNT_W-1:0] flush_count
`endif
);

  typedef enum logic [1:0] {RUN, DWAIT, HALT} state_t;

  state_t state;
  logic   flush_pend;

  // Hazard terms
  logic dmem_req, lu, ml, bh, dstall;
  logic run_dwait;   // RUN cycle frozen by an outstanding data access
  logic run_stall;   // RUN cycle stalled by dstall or an ihit wait
  logic set_pend;

  assign dmem_req = mem_dREN | mem_dWEN;

  assign lu = ex_dREN & ex_rfWEN & (ex_dest != '0) &
              ((ex_dest == dec_rs) | (dec_uses_rt & (ex_dest == dec_rt)));

  // The MEM-stage forward carries the ALU result, not load data, so a load
  // sitting in MEM still blocks its consumer: load-use costs two bubbles.
  assign ml = mem_dREN & mem_rfWEN & (mem_dest != '0) &
              ((mem_dest == dec_rs) | (dec_uses_rt & (mem_dest == dec_rt)));

  assign bh = dec_branch & ex_rfWEN & (ex_dest != '0) &
              ((ex_dest == dec_rs) | (ex_dest == dec_rt));

  assign dstall = ml | lu | bh;

  assign run_dwait = !RST && !wb_halt && (state == RUN) && dmem_req && !dhit;
  assign run_stall = !RST && !wb_halt && (state == RUN) && !(dmem_req && !dhit) &&
                     (dstall || !ihit);

  // A redirect seen while fetch is stalled must still kill the wrong-path
  // instruction once IF/ID next loads. Redirects during dstall are dropped:
  // decode re-resolves the branch after the stall.
  assign set_pend = !RST && !wb_halt && (state == RUN) && dec_redirect &&
                    !ihit && !dstall;

  // NOTE: every output gets a default at the top of the block so no path
  // leaves one unassigned, which would otherwise infer a latch.
  always_comb begin
    pc_en      = 1'b0;
    ifid_en    = 1'b0;
    idex_en    = 1'b0;
    exmem_en   = 1'b0;
    memwb_en   = 1'b0;
    ifid_flush = 1'b0;
    idex_flush = 1'b0;
    if (!RST && !wb_halt) begin
      unique case (state)
        RUN: begin
          if (dmem_req && !dhit) begin
            // whole pipe frozen until the data access completes
          end else if (dstall || !ihit) begin
            // Hold PC and IF/ID; ID/EX loads a bubble (the flush acts
            // through the latch, so it stays enabled); downstream drains.
            idex_en    = 1'b1;
            exmem_en   = 1'b1;
            memwb_en   = 1'b1;
            idex_flush = 1'b1;
          end else begin
            pc_en      = 1'b1;
            ifid_en    = 1'b1;
            idex_en    = 1'b1;
            exmem_en   = 1'b1;
            memwb_en   = 1'b1;
            ifid_flush = dec_redirect | flush_pend;
          end
        end
        DWAIT: begin
          pc_en      = dhit;
          ifid_en    = dhit;
          idex_en    = dhit;
          exmem_en   = dhit;
          memwb_en   = dhit;
          ifid_flush = dhit & (dec_redirect | flush_pend);
        end
        default: ;  // HALT: everything held
      endcase
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state      <= RUN;
      flush_pend <= 1'b0;
      halted     <= 1'b0;
    end else if (wb_halt) begin
      state  <= HALT;
      halted <= 1'b1;
    end else begin
      unique case (state)
        RUN:     if (dmem_req && !dhit) state <= DWAIT;
        DWAIT:   if (dhit)              state <= RUN;
        default: state <= HALT;
      endcase
      if (ifid_flush)    flush_pend <= 1'b0;
      else if (set_pend) flush_pend <= 1'b1;
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  logic dwait_inc;
  assign dwait_inc = run_dwait ||
                     (!RST && !wb_halt && (state == DWAIT) && !dhit);

  // Counters only step on cycles that cannot occur in HALT, so they freeze
  // there without an explicit state check.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      stall_cycles <= '0;
      dwait_cycles <= '0;
      flush_count  <= '0;
    end else begin
      if (run_stall && (stall_cycles != '1)) stall_cycles <= stall_cycles + CNT_W'(1);
      if (dwait_inc && (dwait_cycles != '1)) dwait_cycles <= dwait_cycles + CNT_W'(1);
      if (ifid_flush && (flush_count != '1)) flush_count  <= flush_count + CNT_W'(1);
    end
  end
`else
  logic unused_run;
  assign unused_run = run_dwait ^ run_stall;
`endif

endmodule

// File: tb/tb_hazard_unit.sv
// -----------------------------------------------------------------------------
// tb_hazard_unit
//   Directed bench for hazard_unit. Each step drives decode/pipeline inputs
//   just after a rising edge, pushes the expected control vector onto a
//   scoreboard queue, and the check pops and compares it on the falling edge.
//   Vector order: {pc_en, ifid_en, idex_en, exmem_en, memwb_en,
//                  ifid_flush, idex_flush, halted}
// -----------------------------------------------------------------------------
module tb_hazard_unit;

  localparam int REG_W = 5;
  localparam int CNT_W = 32;

  localparam logic [7:0] V_OFF   = 8'b00000_000;  // all held, no flush
  localparam logic [7:0] V_RUN   = 8'b11111_000;  // full advance
  localparam logic [7:0] V_STALL = 8'b00111_010;  // PC/IF-ID held, bubble into ID/EX
  localparam logic [7:0] V_REDIR = 8'b11111_100;  // advance and kill IF/ID
  localparam logic [7:0] V_HALT  = 8'b00000_001;  // halted, all held

  logic             CLK = 1'b0;
  logic             RST;
  logic             ihit, dhit, mem_dREN, mem_dWEN, mem_rfWEN;
  logic [REG_W-1:0] mem_dest, ex_dest, dec_rs, dec_rt;
  logic             ex_dREN, ex_rfWEN, dec_uses_rt, dec_branch, dec_redirect, wb_halt;
  logic             pc_en, ifid_en, idex_en, exmem_en, memwb_en;
  logic             ifid_flush, idex_flush, halted;
`ifdef HAZARD_PERF_CNT_EN
  logic [CNT_W-1:0] stall_cycles, dwait_cycles, flush_count;
`endif

  always #5 CLK = ~CLK;

  hazard_unit #(.REG_W(REG_W), .CNT_W(CNT_W)) dut (
    .CLK(CLK), .RST(RST), .ihit(ihit), .dhit(dhit),
    .mem_dREN(mem_dREN), .mem_dWEN(mem_dWEN), .mem_rfWEN(mem_rfWEN), .mem_dest(mem_dest),
    .ex_dREN(ex_dREN), .ex_rfWEN(ex_rfWEN), .ex_dest(ex_dest),
    .dec_rs(dec_rs), .dec_rt(dec_rt), .dec_uses_rt(dec_uses_rt),
    .dec_branch(dec_branch), .dec_redirect(dec_redirect), .wb_halt(wb_halt),
    .pc_en(pc_en), .ifid_en(ifid_en), .idex_en(idex_en), .exmem_en(exmem_en),
    .memwb_en(memwb_en), .ifid_flush(ifid_flush), .idex_flush(idex_flush), .halted(halted)
`ifdef HAZARD_PERF_CNT_EN
    , .stall_cycles(stall_cycles), .dwait_cycles(dwait_cycles), .flush_count(flush_count)
`endif
  );

  typedef struct {
    string      tag;
    logic [7:0] v;
  } exp_t;

  exp_t sb[$];
  int   vectors = 0;
  int   miscompares = 0;

  task automatic idle();
    ihit = 1'b1; dhit = 1'b1;
    mem_dREN = 1'b0; mem_dWEN = 1'b0; mem_rfWEN = 1'b0; mem_dest = '0;
    ex_dREN = 1'b0; ex_rfWEN = 1'b0; ex_dest = '0;
    dec_rs = '0; dec_rt = '0; dec_uses_rt = 1'b0;
    dec_branch = 1'b0; dec_redirect = 1'b0; wb_halt = 1'b0;
  endtask

  task automatic push(input string tag, input logic [7:0] v);
    exp_t e;
    e.tag = tag;
    e.v   = v;
    sb.push_back(e);
  endtask

  // Compare on the falling edge, then return 1 ns after the next rising edge
  // so the caller drives the following step away from the active edge.
  task automatic check();
    exp_t       e;
    logic [7:0] obs;
    @(negedge CLK);
    obs = {pc_en, ifid_en, idex_en, exmem_en, memwb_en, ifid_flush, idex_flush, halted};
    vectors++;
    if (sb.size() == 0) begin
      miscompares++;
      $error("FAIL scoreboard_empty observed=%b expected=<entry>", obs);
    end else begin
      e = sb.pop_front();
      assert (obs === e.v) else begin
        miscompares++;
        $error("FAIL %s observed=%b expected=%b", e.tag, obs, e.v);
      end
    end
    @(posedge CLK);
    #1;
  endtask

  initial begin
    idle();
    RST = 1'b1;
    @(posedge CLK); #1;
    push("reset_hold", V_OFF); check();

    RST = 1'b0;
    push("idle_run", V_RUN); check();

    // Load-use: lw $2 in EX, add $2 in decode -> two bubbles
    ex_dREN = 1; ex_rfWEN = 1; ex_dest = 2; dec_rs = 2; dec_rt = 5; dec_uses_rt = 1;
    push("lu_ex", V_STALL); check();
    idle(); mem_dREN = 1; mem_rfWEN = 1; mem_dest = 2; dec_rs = 2; dec_rt = 5; dec_uses_rt = 1;
    push("lu_mem", V_STALL); check();
    idle(); dec_rs = 2; dec_rt = 5; dec_uses_rt = 1;
    push("lu_release", V_RUN); check();

    // rt match only counts when decode reads rt; $0 never stalls
    idle(); ex_dREN = 1; ex_rfWEN = 1; ex_dest = 4; dec_rs = 1; dec_rt = 4; dec_uses_rt = 1;
    push("lu_rt_used", V_STALL); check();
    dec_uses_rt = 0;
    push("lu_rt_unused", V_RUN); check();
    idle(); ex_dREN = 1; ex_rfWEN = 1; ex_dest = 0; dec_rs = 0;
    push("lu_zero_reg", V_RUN); check();

    // Branch dependence: beq $3 with addi $3 in EX; redirect ignored while stalled
    idle(); dec_branch = 1; dec_rs = 3; dec_rt = 7; ex_rfWEN = 1; ex_dest = 3; dec_redirect = 1;
    push("br_stall", V_STALL); check();
    idle(); dec_branch = 1; dec_rs = 3; dec_rt = 7; mem_rfWEN = 1; mem_dest = 3; dec_redirect = 1;
    push("br_redirect", V_REDIR); check();
    idle();
    push("br_after", V_RUN); check();

    // Data wait: sw in MEM, dhit low three cycles
    idle(); mem_dWEN = 1; dhit = 0;
    push("dwait_1", V_OFF); check();
    push("dwait_2", V_OFF); check();
    push("dwait_3", V_OFF); check();
    // dstall and ihit are ignored in DWAIT: the dhit cycle advances once
    dhit = 1; ihit = 0; ex_dREN = 1; ex_rfWEN = 1; ex_dest = 6; dec_rs = 6;
    push("dwait_done", V_RUN); check();
    idle(); ihit = 0;
    push("dwait_back_run", V_STALL); check();

    // Deferred flush: redirect during two ihit-miss cycles
    idle(); ihit = 0; dec_redirect = 1;
    push("defer_miss1", V_STALL); check();
    push("defer_miss2", V_STALL); check();
    idle();
    push("defer_apply", V_REDIR); check();
    push("defer_cleared", V_RUN); check();

    // Pending flush waits out a dstall cycle, then applies
    idle(); ihit = 0; dec_redirect = 1;
    push("defer_set", V_STALL); check();
    idle(); ex_dREN = 1; ex_rfWEN = 1; ex_dest = 8; dec_rs = 8;
    push("defer_dstall", V_STALL); check();
    idle();
    push("defer_late", V_REDIR); check();
    push("defer_late_clr", V_RUN); check();

    // Reset discards a pending flush
    idle(); ihit = 0; dec_redirect = 1;
    push("pend_before_rst", V_STALL); check();
    idle(); RST = 1;
    push("pend_rst", V_OFF); check();
    RST = 0;
    push("pend_discarded", V_RUN); check();

    // Reset discards DWAIT: dhit low with no request must run in RUN
    idle(); mem_dREN = 1; dhit = 0;
    push("dw_enter", V_OFF); check();
    RST = 1;
    push("dw_rst", V_OFF); check();
    RST = 0; mem_dREN = 0; dhit = 0;
    push("dw_discarded", V_RUN); check();

    // Halt during DWAIT, dhit ignored
    idle(); mem_dWEN = 1; dhit = 0;
    push("halt_dwait", V_OFF); check();
    dhit = 1; wb_halt = 1;
    push("halt_assert", V_OFF); check();
    idle();
    push("halt_sticky1", V_HALT); check();
    push("halt_sticky2", V_HALT); check();
    RST = 1;
    push("halt_rst", V_OFF); check();
    RST = 0;
    push("halt_released", V_RUN); check();

`ifdef HAZARD_PERF_CNT_EN
    // Load-use plus a 3-cycle data wait from a fresh reset
    idle(); RST = 1;
    push("perf_rst", V_OFF); check();
    RST = 0; ex_dREN = 1; ex_rfWEN = 1; ex_dest = 2; dec_rs = 2;
    push("perf_lu1", V_STALL); check();
    idle(); mem_dREN = 1; mem_rfWEN = 1; mem_dest = 2; dec_rs = 2;
    push("perf_lu2", V_STALL); check();
    idle();
    push("perf_lu3", V_RUN); check();
    mem_dWEN = 1; dhit = 0;
    push("perf_dw1", V_OFF); check();
    push("perf_dw2", V_OFF); check();
    push("perf_dw3", V_OFF); check();
    dhit = 1;
    push("perf_dw_done", V_RUN); check();
    idle();
    vectors++;
    assert (stall_cycles === CNT_W'(2)) else begin
      miscompares++;
      $error("FAIL perf_stall observed=%0d expected=2", stall_cycles);
    end
    vectors++;
    assert (dwait_cycles === CNT_W'(3)) else begin
      miscompares++;
      $error("FAIL perf_dwait observed=%0d expected=3", dwait_cycles);
    end
    vectors++;
    assert (flush_count === CNT_W'(0)) else begin
      miscompares++;
      $error("FAIL perf_flush observed=%0d expected=0", flush_count);
    end
`endif

    if (sb.size() != 0) begin
      miscompares++;
      $error("FAIL scoreboard_leftover observed=%0d expected=0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/hazard_unit.md
Name: hazard_unit

Overview:
- Pipeline control block for the 5-stage MIPS core. It sits beside the operand-forwarding logic and covers the hazards forwarding cannot resolve: load-use, branch operands not yet available, and memory wait states.
- Outputs drive the per-latch enable and flush inputs of IF/ID, ID/EX, EX/MEM and MEM/WB, plus PC enable.
- It holds the state for memory-wait tracking, deferred branch flush and halt.

Parameters:
- REG_W, 5, register index width
- CNT_W, 32, width of performance counters (used only with the optional feature)

Ports:
- CLK  in  1  core clock
- RST  in  1  asynchronous, active-high reset
- ihit  in  1  instruction fetch completes this cycle
- dhit  in  1  data access completes this cycle
- mem_dREN  in  1  MEM-stage instruction reads dmem
- mem_dWEN  in  1  MEM-stage instruction writes dmem
- mem_rfWEN  in  1  MEM-stage instruction writes the register file
- mem_dest  in  REG_W  MEM-stage destination register
- ex_dREN  in  1  EX-stage instruction is a load
- ex_rfWEN  in  1  EX-stage instruction writes the register file
- ex_dest  in  REG_W  EX-stage destination register
- dec_rs  in  REG_W  decode-stage rs
- dec_rt  in  REG_W  decode-stage rt
- dec_uses_rt  in  1  decode instruction reads rt
- dec_branch  in  1  decode instruction is BEQ/BNE
- dec_redirect  in  1  taken branch or jump resolved in decode
- wb_halt  in  1  HALT reached WB
- pc_en  out  1  PC update enable
- ifid_en, idex_en, exmem_en, memwb_en  out  1 each  latch enables
- ifid_flush, idex_flush  out  1 each  synchronous bubble insert
- halted  out  1  core halted (sticky)

Behaviour:
- Reset values:
  - state = RUN; flush_pend = 0; halted = 0.
  - All enables = 0 and all flushes = 0 while RST is high.
  - After reset release, outputs follow the combinational rules below.
- States: RUN, DWAIT, HALT.
- Hazard terms (combinational):
  - dmem_req = mem_dREN | mem_dWEN
  - lu = ex_dREN & ex_rfWEN & ex_dest≠0 & (ex_dest==dec_rs | dec_uses_rt & ex_dest==dec_rt)
  - ml = mem_dREN & mem_rfWEN & mem_dest≠0 & (mem_dest==dec_rs | dec_uses_rt & mem_dest==dec_rt)
  - bh = dec_branch & ex_rfWEN & ex_dest≠0 & (ex_dest==dec_rs | ex_dest==dec_rt)
  - dstall = ml | lu | bh. This causes two bubbles on load-use, because the MEM-stage forward carries the ALU result, not load data.
- RUN:
  - If dmem_req & !dhit: freeze every latch and the PC (all enables = 0); next state = DWAIT.
  - Else if dstall: pc_en = 0, ifid_en = 0, idex_flush = 1; exmem_en = memwb_en = 1.
  - Else if !ihit: pc_en = 0, ifid_en = 0, idex_flush = 1; downstream latches advance.
  - Else: all enables = 1.
    - If dec_redirect or flush_pend: ifid_flush = 1, and flush_pend clears.
- Deferred flush:
  - dec_redirect while ihit = 0 sets flush_pend.
  - The flush is applied on the first later cycle in which IF/ID is enabled.
- DWAIT:
  - All enables = dhit.
  - On dhit, advance exactly once and return to RUN.
  - dstall and ihit are not evaluated in DWAIT.
- Halt:
  - wb_halt from any state sets halted and moves to HALT.
  - HALT: all enables = 0 and all flushes = 0; exit only via RST.
- Priority: RST > wb_halt > dmem wait > dstall > ihit wait > redirect flush.
- Reset asserted mid-DWAIT or with flush_pend set: both are discarded.
- dec_redirect is ignored in any cycle where dstall = 1. Decode re-resolves the branch after the stall.

Optional Feature:
- Macro: HAZARD_PERF_CNT_EN.
- When defined:
  - Extra outputs: stall_cycles, dwait_cycles, flush_count (each CNT_W bits, out).
  - stall_cycles increments on every RUN cycle with dstall or an ihit wait.
  - dwait_cycles increments on every cycle with pc_en = 0 caused by a data-memory wait, counted in RUN and DWAIT.
  - flush_count increments on every ifid_flush.
  - Counters saturate at all-ones, freeze in HALT and reset to 0.
- When undefined: these ports and their logic are absent; behaviour is otherwise identical.

Test Plan:
- Load-use: lw $2 in EX, add using $2 in decode, ihit = 1, dhit = 1.
  - Expect pc_en = 0 and idex_flush = 1 for 2 consecutive cycles, then all enables = 1.
- Branch dependence: beq $3 in decode with addi $3 in EX.
  - Expect 1 stall cycle.
  - Then the MEM forward covers the operand, no further stall, and dec_redirect flushes IF/ID.
- Data wait: sw in MEM with dhit low for 3 cycles.
  - Expect all enables = 0 for 3 cycles (state DWAIT), enables = 1 on the dhit cycle, RUN next.
- Deferred flush: dec_redirect = 1 while ihit = 0 for 2 cycles.
  - Expect no ifid_flush while ihit = 0.
  - On the first ihit cycle, ifid_flush = 1 and flush_pend clears.
- Halt: wb_halt = 1 during DWAIT.
  - Expect halted = 1 next cycle and all enables held at 0 despite dhit.
  - RST pulse returns the block to RUN with halted = 0.
- With HAZARD_PERF_CNT_EN defined: run the load-use plus 3-cycle data-wait sequence.
  - Expect stall_cycles = 2, dwait_cycles = 3, flush_count unchanged.
